bridge_tx_serializer: RTL

//   Terminal stage of the daisy-chained register bus. Consumes the 16-bit addr/data/rw/valid

---
 rtl/bridge_tx_serializer_pkg.sv | 18 +
 rtl/bridge_tx_serializer_resp_fifo.sv | 55 +++++
 rtl/bridge_tx_serializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bridge_tx_serializer_pkg.sv
// Shared constants and types for the bridge TX serializer.
// Frame layout is "M" + 4 hex digits + CR + LF.
package bridge_tx_serializer_pkg;

  localparam int FRAME_LEN = 7;

  localparam logic [7:0] ASCII_M       = 8'h4D;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;
  localparam logic [7:0] HEX_NUM_OFS   = 8'h30;
  localparam logic [7:0] HEX_ALPHA_OFS = 8'h37;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_e;

endpackage

// File: rtl/bridge_tx_serializer_resp_fifo.sv
// Read-response FIFO, synchronous, first-word fall-through.
// Full FIFO rejects a push even when a pop happens that cycle.
module bridge_tx_serializer_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bridge_tx_serializer.sv
// Bus read responses to ASCII "Mhhhh\r\n" frames.
// Bytes go one at a time to the UART over valid/ready.
module bridge_tx_serializer
  import bridge_tx_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  tx_state_e       state;
  logic [2:0]      idx;
  logic [15:0]     shreg;
  logic            head_rdy_q;
  logic            rd_req;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [15:0]     head;
  logic [CW-1:0]   count;
  logic            unused_addr;

  assign unused_addr = ^addr_i;

  assign rd_req = valid_i && !rw_i;
  assign push   = rd_req && !full;
  assign pop    = (state == IDLE) && head_rdy_q && !empty;

  bridge_tx_serializer_resp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (data_i),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  function automatic logic [7:0] nib_ascii(
    input logic [3:0] n
  );
    if (n < 4'd10) return HEX_NUM_OFS + {4'h0, n};
    return HEX_ALPHA_OFS + {4'h0, n};
  endfunction

  function automatic logic [7:0] frame_byte(
    input logic [15:0] w,
    input logic [2:0]  i
  );
    logic [7:0] b;
    b = ASCII_M;
    case (i)
      3'd1:    b = nib_ascii(w[15:12]);
      3'd2:    b = nib_ascii(w[11:8]);
      3'd3:    b = nib_ascii(w[7:4]);
      3'd4:    b = nib_ascii(w[3:0]);
      3'd5:    b = ASCII_CR;
      3'd6:    b = ASCII_LF;
      default: b = ASCII_M;
    endcase
    return b;
  endfunction

  // Frame FSM; the head-ready flag is registered so a freshly
  // pushed word waits one settle cycle before it is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      head_rdy_q <= 1'b0;
      data_o     <= 8'h00;
      valid_o    <= 1'b0;
    end else begin
      head_rdy_q <= (count != '0);
      unique case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= head;
            idx     <= '0;
            data_o  <= ASCII_M;
            valid_o <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          if (valid_o && ready_i) begin
            if (idx == LAST_IDX) begin
              idx     <= '0;
              valid_o <= 1'b0;
              state   <= IDLE;
            end else begin
              idx    <= idx + 3'd1;
              data_o <= frame_byte(shreg, idx + 3'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky drop flag and registered busy status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      if (rd_req && full) overflow_o <= 1'b1;
      busy_o <= (state != IDLE) || (count != '0);
    end
  end

endmodule
